button_event: RTL and testbench

- Consumes the clean, single-clock-domain level from the debounce stage and turns it into one-cycle event strobes.
- Strobes: press, release, long-press, and auto-repeat while held.
- Also keeps a wrapping count of presses.
- Sits between the per-button debounce instance and the control FSM / UI logic, so downstream logic never does its own edge detection or hold timing.

---
 rtl/button_event.sv | 139 +++++++++++++
 tb/tb_button_event.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// button_event: turns a debounced, clk-synchronous button level into one-cycle
// press / release / long / repeat strobes, a held level and a wrapping press
// counter. The strobes named release_evt and repeat_evt carry the release and
// repeat events (release and repeat are reserved words in SystemVerilog).
module button_event #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26,
    parameter int PCNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn,
    output logic              press,
    output logic              release_evt,
    output logic              long,
    output logic              repeat_evt,
    output logic              held,
    output logic [PCNT_W-1:0] press_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } state_e;

    // Terminal counts: the counter restarts from zero on every state entry,
    // so it reaches LAST after exactly *_CYCLES-1 further edges.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [PCNT_W-1:0] PCNT_ONE   = PCNT_W'(1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                btn_q, btn_d;
    logic                press_q, press_d;
    logic                release_q, release_d;
    logic                long_q, long_d;
    logic                repeat_q, repeat_d;
    logic                held_q, held_d;
    logic [PCNT_W-1:0]   press_count_q, press_count_d;
    logic                rise_s;
    logic                fall_s;

    // Next-state, counter and strobe computation; a falling edge always wins
    // over a threshold hit so a release never coincides with long/repeat.
    always_comb begin
        rise_s        = btn & ~btn_q;
        fall_s        = ~btn & btn_q;
        btn_d         = btn;
        state_d       = state_q;
        cnt_d         = cnt_q;
        press_d       = 1'b0;
        release_d     = 1'b0;
        long_d        = 1'b0;
        repeat_d      = 1'b0;
        press_count_d = press_count_q;

        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    press_d       = 1'b1;
                    press_count_d = press_count_q + PCNT_ONE;
                    cnt_d         = '0;
                    state_d       = ST_PRESSED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (fall_s) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (fall_s) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                // Unreachable encoding: recover silently to IDLE.
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        held_d = (state_d != ST_IDLE);
    end

    // State, counter, input history and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            btn_q         <= 1'b0;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            long_q        <= 1'b0;
            repeat_q      <= 1'b0;
            held_q        <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            btn_q         <= btn_d;
            press_q       <= press_d;
            release_q     <= release_d;
            long_q        <= long_d;
            repeat_q      <= repeat_d;
            held_q        <= held_d;
            press_count_q <= press_count_d;
        end
    end

    assign press       = press_q;
    assign release_evt = release_q;
    assign long        = long_q;
    assign repeat_evt  = repeat_q;
    assign held        = held_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_button_event.sv
// Directed self-checking bench for button_event (LONG=4, REPEAT=2).
// Observed vector layout: {press, release, long, repeat, held}.
module tb_button_event;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic       btn2;
    logic       press_s, release_s, long_s, repeat_s, held_s;
    logic [7:0] pcount_s;
    logic       press2_s, release2_s, long2_s, repeat2_s, held2_s;
    logic [1:0] pcount2_s;

    int         n_checks;
    int         n_fail;
    logic [7:0] exp_pc;

    button_event #(
        .LONG_CYCLES(4), .REPEAT_CYCLES(2), .CNT_W(4), .PCNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn),
        .press(press_s), .release_evt(release_s), .long(long_s),
        .repeat_evt(repeat_s), .held(held_s), .press_count(pcount_s)
    );

    button_event #(
        .LONG_CYCLES(4), .REPEAT_CYCLES(2), .CNT_W(4), .PCNT_W(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .btn(btn2),
        .press(press2_s), .release_evt(release2_s), .long(long2_s),
        .repeat_evt(repeat2_s), .held(held2_s), .press_count(pcount2_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] obs1();
        return {press_s, release_s, long_s, repeat_s, held_s};
    endfunction

    function automatic logic [4:0] obs2();
        return {press2_s, release2_s, long2_s, repeat2_s, held2_s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            btn  = ~btn;
            btn2 = ~btn2;
            tick();
            n_checks++;
            if (obs1() !== 5'b00000 || pcount_s !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %b/%0d expected 00000/0", i, obs1(), pcount_s);
            end
            n_checks++;
            if (obs2() !== 5'b00000 || pcount2_s !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_hold2 cycle %0d: got %b/%0d expected 00000/0", i, obs2(), pcount2_s);
            end
        end
        btn   = 1'b0;
        btn2  = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs1() !== 5'b00000 || pcount_s !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %b/%0d expected 00000/0", i, obs1(), pcount_s);
            end
        end
        exp_pc = 8'd0;
    endtask

    task automatic test_short_press();
        logic       btn_v [0:3] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [4:0] exp_v [0:3] = '{5'b10001, 5'b00001, 5'b01000, 5'b00000};
        for (int i = 0; i < 4; i++) begin
            btn = btn_v[i];
            tick();
            if (exp_v[i][4]) exp_pc = exp_pc + 8'd1;
            n_checks++;
            if (obs1() !== exp_v[i]) begin
                n_fail++;
                $display("FAIL short_press cycle %0d: got %b expected %b", i, obs1(), exp_v[i]);
            end
            n_checks++;
            if (pcount_s !== exp_pc) begin
                n_fail++;
                $display("FAIL short_press_count cycle %0d: got %0d expected %0d", i, pcount_s, exp_pc);
            end
        end
    endtask

    task automatic test_long_repeat();
        logic       btn_v [0:12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                     1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [4:0] exp_v [0:12] = '{5'b10001, 5'b00001, 5'b00001, 5'b00001,
                                     5'b00101, 5'b00001, 5'b00011, 5'b00001,
                                     5'b00011, 5'b00001, 5'b00011, 5'b01000,
                                     5'b00000};
        for (int i = 0; i < 13; i++) begin
            btn = btn_v[i];
            tick();
            if (exp_v[i][4]) exp_pc = exp_pc + 8'd1;
            n_checks++;
            if (obs1() !== exp_v[i]) begin
                n_fail++;
                $display("FAIL long_repeat cycle %0d: got %b expected %b", i, obs1(), exp_v[i]);
            end
            n_checks++;
            if (pcount_s !== exp_pc) begin
                n_fail++;
                $display("FAIL long_repeat_count cycle %0d: got %0d expected %0d", i, pcount_s, exp_pc);
            end
        end
    endtask

    task automatic test_release_at_threshold();
        logic       btn_v [0:5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [4:0] exp_v [0:5] = '{5'b10001, 5'b00001, 5'b00001, 5'b00001,
                                    5'b01000, 5'b00000};
        for (int i = 0; i < 6; i++) begin
            btn = btn_v[i];
            tick();
            if (exp_v[i][4]) exp_pc = exp_pc + 8'd1;
            n_checks++;
            if (obs1() !== exp_v[i]) begin
                n_fail++;
                $display("FAIL release_at_threshold cycle %0d: got %b expected %b", i, obs1(), exp_v[i]);
            end
        end
        n_checks++;
        if (pcount_s !== exp_pc) begin
            n_fail++;
            $display("FAIL release_at_threshold_count: got %0d expected %0d", pcount_s, exp_pc);
        end
    endtask

    task automatic test_back_to_back();
        logic       btn_v [0:8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                    1'b1, 1'b0, 1'b0};
        logic [4:0] exp_v [0:8] = '{5'b10001, 5'b00001, 5'b01000, 5'b10001,
                                    5'b00001, 5'b01000, 5'b10001, 5'b01000,
                                    5'b00000};
        for (int i = 0; i < 9; i++) begin
            btn = btn_v[i];
            tick();
            if (exp_v[i][4]) exp_pc = exp_pc + 8'd1;
            n_checks++;
            if (obs1() !== exp_v[i]) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", i, obs1(), exp_v[i]);
            end
            n_checks++;
            if (pcount_s !== exp_pc) begin
                n_fail++;
                $display("FAIL back_to_back_count cycle %0d: got %0d expected %0d", i, pcount_s, exp_pc);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        btn = 1'b1;
        tick();
        exp_pc = exp_pc + 8'd1;
        n_checks++;
        if (obs1() !== 5'b10001 || pcount_s !== exp_pc) begin
            n_fail++;
            $display("FAIL mid_hold_press: got %b/%0d expected 10001/%0d", obs1(), pcount_s, exp_pc);
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs1() !== 5'b00000 || pcount_s !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_hold_async_clear: got %b/%0d expected 00000/0", obs1(), pcount_s);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (obs1() !== 5'b00000) begin
                n_fail++;
                $display("FAIL mid_hold_in_reset cycle %0d: got %b expected 00000", i, obs1());
            end
        end
        rst_n  = 1'b1;
        exp_pc = 8'd0;
        tick();
        exp_pc = exp_pc + 8'd1;
        n_checks++;
        if (obs1() !== 5'b10001 || pcount_s !== exp_pc) begin
            n_fail++;
            $display("FAIL post_reset_press: got %b/%0d expected 10001/%0d", obs1(), pcount_s, exp_pc);
        end
        tick();
        n_checks++;
        if (obs1() !== 5'b00001) begin
            n_fail++;
            $display("FAIL post_reset_held: got %b expected 00001", obs1());
        end
        btn = 1'b0;
        tick();
        n_checks++;
        if (obs1() !== 5'b01000 || pcount_s !== 8'd1) begin
            n_fail++;
            $display("FAIL post_reset_release: got %b/%0d expected 01000/1", obs1(), pcount_s);
        end
        tick();
    endtask

    task automatic test_counter_wrap();
        logic [1:0] exp_c [0:4] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int k = 0; k < 5; k++) begin
            btn2 = 1'b1;
            tick();
            n_checks++;
            if (obs2() !== 5'b10001 || pcount2_s !== exp_c[k]) begin
                n_fail++;
                $display("FAIL wrap_press %0d: got %b/%0d expected 10001/%0d", k, obs2(), pcount2_s, exp_c[k]);
            end
            btn2 = 1'b0;
            tick();
            n_checks++;
            if (obs2() !== 5'b01000 || pcount2_s !== exp_c[k]) begin
                n_fail++;
                $display("FAIL wrap_release %0d: got %b/%0d expected 01000/%0d", k, obs2(), pcount2_s, exp_c[k]);
            end
        end
        tick();
        n_checks++;
        if (obs2() !== 5'b00000) begin
            n_fail++;
            $display("FAIL wrap_idle: got %b expected 00000", obs2());
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_pc   = 8'd0;
        rst_n    = 1'b0;
        btn      = 1'b0;
        btn2     = 1'b0;
        test_reset();
        test_short_press();
        test_long_repeat();
        test_release_at_threshold();
        test_back_to_back();
        test_reset_mid_hold();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
